// File: rtl/tpu_load_sequencer.sv
// Streams a framed byte sequence into per-element A/B load strobes for the
// 2x2 matmul controller, then waits for the controller's done rising edge.
module tpu_load_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       load_en,
  output logic       load_sel_ab,
  output logic [1:0] load_index,
  output logic [7:0] load_data,
  input  logic       ctrl_done,
  output logic       busy,
  output logic       frame_done,
  output logic       err
);

  typedef enum logic [1:0] {HDR, DATA, WAIT} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state, state_next;
  logic [2:0] k, k_next;
  logic       mode, mode_next;
  logic [7:0] idle, idle_next;
  logic       ctrl_prev;
  logic       load_en_next, sel_next, fd_next, err_next;
  logic [1:0] idx_next;
  logic [7:0] data_next;
  logic       accept, done_rise, last_byte;
  logic [7:0] idle_inc;

  assign in_ready  = (state != WAIT);
  assign accept    = in_valid & in_ready;
  assign done_rise = ctrl_done & ~ctrl_prev;
  assign last_byte = mode ? (k == 3'd3) : (k == 3'd7);
  assign idle_inc  = idle + 8'd1;

  always_comb begin
    state_next   = state;
    k_next       = k;
    mode_next    = mode;
    idle_next    = idle;
    load_en_next = 1'b0;
    sel_next     = load_sel_ab;
    idx_next     = load_index;
    data_next    = load_data;
    fd_next      = 1'b0;
    err_next     = 1'b0;
    case (state)
      HDR: begin
        idle_next = '0;
        if (accept) begin
          if (in_data[7:4] == 4'hA) begin
            state_next = DATA;
            k_next     = '0;
            mode_next  = in_data[0];
          end else begin
            err_next = 1'b1;
          end
        end
      end
      DATA: begin
        if (accept) begin
          load_en_next = 1'b1;
          sel_next     = mode ? 1'b1 : k[2];
          idx_next     = k[1:0];
          data_next    = in_data;
          k_next       = k + 3'd1;
          idle_next    = '0;
          if (last_byte) state_next = WAIT;
        end else if (idle_inc == TIMEOUT_CNT) begin
          err_next   = 1'b1;
          state_next = HDR;
          idle_next  = '0;
        end else begin
          idle_next = idle_inc;
        end
      end
      WAIT: begin
        // A done rise is progress, so it wins over a coincident timeout.
        if (done_rise) begin
          fd_next    = 1'b1;
          state_next = HDR;
          idle_next  = '0;
        end else if (idle_inc == TIMEOUT_CNT) begin
          err_next   = 1'b1;
          state_next = HDR;
          idle_next  = '0;
        end else begin
          idle_next = idle_inc;
        end
      end
      default: state_next = HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HDR;
      k           <= '0;
      mode        <= 1'b0;
      idle        <= '0;
      ctrl_prev   <= 1'b0;
      load_en     <= 1'b0;
      load_sel_ab <= 1'b0;
      load_index  <= '0;
      load_data   <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_next;
      k           <= k_next;
      mode        <= mode_next;
      idle        <= idle_next;
      ctrl_prev   <= ctrl_done;
      load_en     <= load_en_next;
      load_sel_ab <= sel_next;
      load_index  <= idx_next;
      load_data   <= data_next;
      busy        <= (state_next != HDR);
      frame_done  <= fd_next;
      err         <= err_next;
    end
  end

endmodule

// File: tb/tb_tpu_load_sequencer.sv
// Scoreboard bench for tpu_load_sequencer: stimulus pushes expected strobes,
// completions and errors (with their cycle); a negedge monitor pops and compares.
module tb_tpu_load_sequencer;

  localparam int unsigned TO = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       load_en;
  logic       load_sel_ab;
  logic [1:0] load_index;
  logic [7:0] load_data;
  logic       ctrl_done;
  logic       busy;
  logic       frame_done;
  logic       err;

  tpu_load_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .load_en(load_en), .load_sel_ab(load_sel_ab),
    .load_index(load_index), .load_data(load_data), .ctrl_done(ctrl_done),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum logic [1:0] {EV_LOAD, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic       sel;
    logic [1:0] idx;
    logic [7:0] data;
    int         when;
  } ev_t;

  ev_t sbq[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_load(input logic sel, input logic [1:0] idx, input logic [7:0] data,
                           input int when);
    ev_t e;
    e.kind = EV_LOAD; e.sel = sel; e.idx = idx; e.data = data; e.when = when;
    sbq.push_back(e);
  endtask

  task automatic push_ev(input ev_kind_t kind, input int when);
    ev_t e;
    e.kind = kind; e.sel = 1'b0; e.idx = 2'd0; e.data = 8'd0; e.when = when;
    sbq.push_back(e);
  endtask

  // Monitor: every strobe/pulse the DUT shows must match the next expected event.
  always @(negedge clk) begin
    ev_t a;
    ev_t e;
    if (rst_n === 1'b1 && (load_en || frame_done || err)) begin
      a.kind = load_en ? EV_LOAD : (frame_done ? EV_DONE : EV_ERR);
      a.sel  = load_sel_ab;
      a.idx  = load_index;
      a.data = load_data;
      a.when = cyc;
      checks++;
      if ($countones({load_en, frame_done, err}) > 1 || sbq.size() == 0) begin
        failures++;
        $display("FAIL event_unexpected: got load_en=%0b frame_done=%0b err=%0b at cyc %0d expected none (queued=%0d)",
                 load_en, frame_done, err, cyc, sbq.size());
      end else begin
        e = sbq.pop_front();
        if (a.kind != e.kind || a.when != e.when ||
            (e.kind == EV_LOAD && (a.sel !== e.sel || a.idx !== e.idx || a.data !== e.data))) begin
          failures++;
          $display("FAIL event: got kind=%0d sel=%0b idx=%0d data=%02h cyc=%0d expected kind=%0d sel=%0b idx=%0d data=%02h cyc=%0d",
                   a.kind, a.sel, a.idx, a.data, a.when, e.kind, e.sel, e.idx, e.data, e.when);
        end
      end
      if (frame_done || err) chk("busy_low_at_end", {31'd0, busy}, 32'd0);
    end
  end

  // Present a byte at a negedge; returns the cycle in which its effect is visible.
  task automatic send(input logic [7:0] b, output int vis);
    int n;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    vis = cyc + 1;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic done_pulse();
    @(negedge clk);
    in_valid  = 1'b0;
    ctrl_done = 1'b1;
    push_ev(EV_DONE, cyc + 1);
    repeat (2) @(negedge clk);
    ctrl_done = 1'b0;
  endtask

  task automatic frame_b_only(input logic [7:0] base);
    int v;
    send(8'hA1, v);
    for (int i = 0; i < 4; i++) begin
      send(8'(base + i), v);
      push_load(1'b1, 2'(i), 8'(base + i), v);
    end
    done_pulse();
    chk("in_ready_after_done", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_load_en"}, {31'd0, load_en}, 32'd0);
    chk({tag, "_sel"}, {31'd0, load_sel_ab}, 32'd0);
    chk({tag, "_index"}, {30'd0, load_index}, 32'd0);
    chk({tag, "_data"}, {24'd0, load_data}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    int vlast;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    ctrl_done = 1'b0;
    #3 rst_n = 1'b0;
    #1 check_all_zero("reset");
    #10 rst_n = 1'b1;

    // Mode 0 back-to-back, then done rise
    send(8'hA0, v);
    for (int i = 0; i < 8; i++) begin
      send(8'(i + 1), v);
      push_load(logic'(i >= 4), 2'(i % 4), 8'(i + 1), v);
    end
    gap(1);
    chk("wait_busy", {31'd0, busy}, 32'd1);
    chk("wait_in_ready", {31'd0, in_ready}, 32'd0);
    gap(2);
    done_pulse();
    chk("m0_busy_after", {31'd0, busy}, 32'd0);

    // Mode 1 with two-cycle gaps
    send(8'hA1, v);
    for (int i = 0; i < 4; i++) begin
      send(8'(8'h10 * (i + 1)), v);
      push_load(1'b1, 2'(i), 8'(8'h10 * (i + 1)), v);
      gap(2);
    end
    done_pulse();

    // Bad header, then a good mode-1 frame
    send(8'h55, v);
    push_ev(EV_ERR, v);
    gap(1);
    chk("badhdr_busy", {31'd0, busy}, 32'd0);
    frame_b_only(8'h21);

    // Timeout mid-DATA
    send(8'hA0, v);
    for (int i = 0; i < 3; i++) begin
      send(8'(8'h31 + i), vlast);
      push_load(1'b0, 2'(i), 8'(8'h31 + i), vlast);
    end
    push_ev(EV_ERR, vlast + TO);
    gap(TO + 3);
    chk("timeout_busy", {31'd0, busy}, 32'd0);
    chk("timeout_in_ready", {31'd0, in_ready}, 32'd1);
    frame_b_only(8'h41);

    // Enter WAIT with ctrl_done already high and in_valid held
    ctrl_done = 1'b1;
    send(8'hA1, v);
    for (int i = 0; i < 4; i++) begin
      send(8'(8'h51 + i), v);
      push_load(1'b1, 2'(i), 8'(8'h51 + i), v);
    end
    @(negedge clk);
    in_data = 8'hA1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    ctrl_done = 1'b0;
    repeat (2) @(negedge clk);
    done_pulse();

    // Asynchronous reset after the 5th data byte of a mode-0 frame
    send(8'hA0, v);
    for (int i = 0; i < 5; i++) begin
      send(8'(8'h61 + i), v);
      push_load(logic'(i >= 4), 2'(i % 4), 8'(8'h61 + i), v);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    chk("midreset_sb_empty", 32'(sbq.size()), 32'd0);
    #10 rst_n = 1'b1;
    send(8'hA0, v);
    for (int i = 0; i < 8; i++) begin
      send(8'(8'h71 + i), v);
      push_load(logic'(i >= 4), 2'(i % 4), 8'(8'h71 + i), v);
    end
    gap(2);
    done_pulse();

    gap(3);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tpu_load_sequencer.md
# tpu_load_sequencer

Upstream front-end for the 2x2 matrix-multiply controller. Accepts a framed byte stream over a valid/ready handshake, checks the header, and converts the payload into the controller's per-element load strobes (matrix select, element index, data). It then waits for the controller's done indication and reports frame completion or error. It replaces manual pin-toggled loading of A/B with a single streamed transaction.

## Interface
Parameters:
- `TIMEOUT`, default 255: cycles without progress before an in-flight frame is aborted (1..255).

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a byte this cycle.
- `load_en`  out  1  one-cycle load strobe to the controller.
- `load_sel_ab`  out  1  0 = matrix A, 1 = matrix B.
- `load_index`  out  2  element index, row-major (0=[0][0], 1=[0][1], 2=[1][0], 3=[1][1]).
- `load_data`  out  8  element value; valid while `load_en` is high.
- `ctrl_done`  in  1  controller done level.
- `busy`  out  1  a frame is in progress (state ≠ HDR).
- `frame_done`  out  1  one-cycle pulse when a frame completes.
- `err`  out  1  one-cycle pulse on bad header or timeout.

## Operation
- Handshake: a byte is accepted on a rising edge where `in_valid & in_ready`. `in_ready` is combinational from state: 1 in HDR and DATA, 0 in WAIT.
- Header byte: `[7:4]` must be 4'hA. Bit 0 selects the mode:
  - 0: load A then B, 8 data bytes.
  - 1: load B only, 4 data bytes; A is reused.
  - Bits `[3:1]` are ignored.
- States:
  - HDR: accept a header.
    - Valid header -> DATA. The byte counter clears and the mode is latched.
    - Invalid header -> the byte is discarded, `err` pulses, and the state stays HDR.
  - DATA: each accepted byte produces one load strobe. A 3-bit byte counter `k` runs 0..7.
    - Mode 0: `load_sel_ab = k[2]`, `load_index = k[1:0]`.
    - Mode 1: `load_sel_ab = 1`, `load_index = k[1:0]`.
    - After the last byte (k=7 in mode 0, k=3 in mode 1) -> WAIT.
  - WAIT: wait for a rising edge of `ctrl_done`, using a registered previous value that resets to 0 and is sampled every cycle.
    - Rising edge seen -> `frame_done` pulses and the state goes to HDR.
    - A `ctrl_done` that is already high on entry is not a completion; it must fall and rise again.
- Timeout: an 8-bit idle counter clears on state entry and on every progress event (accepted byte in DATA, `ctrl_done` rise in WAIT). It increments on every other cycle in DATA or WAIT. When it reaches `TIMEOUT`:
  - `err` pulses;
  - the state goes to HDR;
  - no `frame_done` pulse is produced.
  - The idle counter does not run in HDR.
- Partial loads are not rolled back. The controller keeps any elements already written.
- `ctrl_done` is ignored in HDR and DATA.

## Timing
- All outputs except `in_ready` are registered.
- Reset values: `load_en` = 0, `load_sel_ab` = 0, `load_index` = 0, `load_data` = 0, `busy` = 0, `frame_done` = 0, `err` = 0. State is HDR, so `in_ready` = 1.
- Load latency: a byte accepted at edge n gives `load_en` = 1 with its sel/index/data during cycle n..n+1. `load_en` is high for exactly one cycle per byte.
- Back-to-back bytes give consecutive-cycle strobes. Throughput is 1 byte/cycle.
- Frame latency:
  - The last data byte accepted at edge n sets `busy` = 1 and WAIT is active from n.
  - The earliest `frame_done` occurs one cycle after the first cycle in which `ctrl_done` is seen rising.
  - `busy` falls in the same cycle that `frame_done` rises.
- `err` for a bad header rises the cycle after acceptance.
- `err` for a timeout rises `TIMEOUT` cycles after the last progress event. `busy` falls in the same cycle.
- Asserting `rst_n` low at any time, including mid-DATA or WAIT, clears all outputs and the state immediately, with no clock required.

## Test plan
- Reset, then stream 0xA0 followed by 0x01..0x08 back-to-back -> eight consecutive strobes (ab,idx,data) = (0,0,01)(0,1,02)(0,2,03)(0,3,04)(1,0,05)(1,1,06)(1,2,07)(1,3,08). After that, a `ctrl_done` 0->1 gives one `frame_done` pulse and `busy` = 0.
- Header 0xA1 + 0x10,0x20,0x30,0x40 with `in_valid` gaps of 2 cycles -> four strobes, all `load_sel_ab` = 1, idx 0..3. Each strobe is one cycle after its byte is accepted.
- Header 0x55 -> `err` pulses 1 cycle, no `load_en`, `busy` stays 0. A subsequent valid 0xA1 frame completes normally.
- 0xA0 + 3 bytes, then `in_valid` = 0 for `TIMEOUT` cycles -> `err` pulses once, state returns to HDR, no `frame_done`. The next header is accepted.
- Enter WAIT with `ctrl_done` already 1 while `in_valid` = 1 -> `in_ready` = 0, nothing is accepted, and there is no `frame_done`. `ctrl_done` 1->0->1 then gives `frame_done`.
- `rst_n` pulsed low after the 5th data byte of a mode-0 frame -> all outputs 0 asynchronously and `in_ready` = 1. A fresh 0xA0 frame after release produces strobes starting at (0,0).
